// File: rtl/counter_ctrl_pkg.sv
// ============================================================================
// counter_ctrl_pkg : shared state encoding and widths for counter_ctrl
// Revision: 1.0
// ============================================================================
`default_nettype none

package counter_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int MAX_DIGIT = 9;
  localparam int CNT_W     = 8;

endpackage

`default_nettype wire

// File: rtl/tick_prescaler.sv
// ============================================================================
// tick_prescaler : free-running divider, one registered tick per TICK_DIV
// Revision: 1.0
// ============================================================================
`default_nettype none

module tick_prescaler #(
  parameter int TICK_DIV = 50_000_000,
  parameter int DIV_W    = $clog2(TICK_DIV)
) (
  input  logic Clock,
  input  logic sResetn,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam logic [DIV_W-1:0] C_LAST = DIV_W'(TICK_DIV - 1);
  // Fire one count early so the registered tick lands TICK_DIV-1 edges after a clear.
  localparam logic [DIV_W-1:0] C_FIRE = DIV_W'(TICK_DIV - 2);

  logic [DIV_W-1:0] r_count;

  always_ff @(posedge Clock or negedge sResetn) begin
    if (!sResetn) begin
      r_count <= '0;
      tick    <= 1'b0;
    end else if (clr) begin
      r_count <= '0;
      tick    <= 1'b0;
    end else if (en) begin
      tick    <= (r_count == C_FIRE);
      r_count <= (r_count == C_LAST) ? '0 : r_count + 1'b1;
    end else begin
      tick    <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/counter_ctrl.sv
// ============================================================================
// counter_ctrl : start/stop sequencer for the mod-10 up/down digit counter
// Option macro: COUNTER_CTRL_AUTORELOAD_EN (reload on target instead of DONE)
// Revision: 1.0
// ============================================================================
`default_nettype none

module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int DIV_W    = $clog2(TICK_DIV)
) (
  input  logic             Clock,
  input  logic             sResetn,
  input  logic             start,
  input  logic             stop,
  input  logic             dir_sel,
  input  logic [3:0]       target,
  input  logic [CNT_W-1:0] count_q,
  output logic             step,
  output logic             updown,
  output logic             cnt_resetn,
  output logic             done,
  output logic [1:0]       state
);

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_tgt;
  logic       r_step_d;
  logic       w_hit;
  logic       w_en;
  logic       w_clr;

  // count_q is only trusted the cycle after a step, once the counter has settled.
  assign w_hit = r_step_d && (r_state == RUN) &&
                 (r_tgt <= 4'(MAX_DIGIT)) && (count_q == CNT_W'(r_tgt));

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start && !stop) w_next = RUN;
      RUN: begin
        if (stop) begin
          w_next = PAUSE;
        end else if (w_hit) begin
`ifdef COUNTER_CTRL_AUTORELOAD_EN
          w_next = RUN;
`else
          w_next = DONE;
`endif
        end
      end
      PAUSE: begin
        if (stop)       w_next = IDLE;
        else if (start) w_next = RUN;
      end
      DONE:    if (start || stop) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Prescaler holds its value outside RUN and on the edge that leaves RUN.
  assign w_en  = (r_state == RUN) && (w_next == RUN);
  assign w_clr = (r_state == IDLE);

  tick_prescaler #(
    .TICK_DIV (TICK_DIV),
    .DIV_W    (DIV_W)
  ) u_prescaler (
    .Clock   (Clock),
    .sResetn (sResetn),
    .clr     (w_clr),
    .en      (w_en),
    .tick    (step)
  );

  always_ff @(posedge Clock or negedge sResetn) begin
    if (!sResetn) begin
      r_state    <= IDLE;
      r_tgt      <= 4'd0;
      r_step_d   <= 1'b0;
      updown     <= 1'b1;
      cnt_resetn <= 1'b0;
      done       <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_step_d <= step;
      if ((r_state == IDLE) && (w_next == RUN)) begin
        r_tgt  <= target;
        updown <= dir_sel;
      end
`ifdef COUNTER_CTRL_AUTORELOAD_EN
      cnt_resetn <= (w_next != IDLE) && !(w_hit && !stop);
      done       <= w_hit && !stop;
`else
      cnt_resetn <= (w_next != IDLE);
      done       <= (w_next == DONE);
`endif
    end
  end

  assign state = r_state;

endmodule

`default_nettype wire

// File: tb/tb_counter_ctrl.sv
// ============================================================================
// tb_counter_ctrl : directed bench for counter_ctrl with a mod-10 counter model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_counter_ctrl;

  logic       Clock;
  logic       sResetn;
  logic       start;
  logic       stop;
  logic       dir_sel;
  logic [3:0] target;
  logic [7:0] count_q;
  logic       step;
  logic       updown;
  logic       cnt_resetn;
  logic       done;
  logic [1:0] state;

  int n_chk  = 0;
  int n_fail = 0;

  counter_ctrl #(
    .TICK_DIV (4)
  ) dut (
    .Clock      (Clock),
    .sResetn    (sResetn),
    .start      (start),
    .stop       (stop),
    .dir_sel    (dir_sel),
    .target     (target),
    .count_q    (count_q),
    .step       (step),
    .updown     (updown),
    .cnt_resetn (cnt_resetn),
    .done       (done),
    .state      (state)
  );

  // Mod-10 up/down digit counter clocked by step, cleared by cnt_resetn.
  always @(posedge step or negedge cnt_resetn) begin
    if (!cnt_resetn)  count_q <= 8'd0;
    else if (updown)  count_q <= (count_q == 8'd9) ? 8'd0 : count_q + 8'd1;
    else              count_q <= (count_q == 8'd0) ? 8'd9 : count_q - 8'd1;
  end

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic cycle(input int n);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic pulse(input logic s, input logic p);
    start = s;
    stop  = p;
    cycle(1);
    start = 1'b0;
    stop  = 1'b0;
  endtask

  // Cycles until step is seen high, bounded; a timeout shows up as a bad count.
  task automatic step_after(input string tag, input int exp);
    int n;
    n = 0;
    do begin
      cycle(1);
      n++;
    end while (!step && n < 50);
    chk(tag, n, exp);
  endtask

  initial begin
    int quiet;
    sResetn = 1'b0;
    start   = 1'b0;
    stop    = 1'b0;
    dir_sel = 1'b1;
    target  = 4'd0;
    cycle(2);
    chk("rst_state", state, 0);
    chk("rst_step", step, 0);
    chk("rst_updown", updown, 1);
    chk("rst_cnt_resetn", cnt_resetn, 0);
    chk("rst_done", done, 0);
    chk("rst_count", count_q, 0);
    sResetn = 1'b1;
    cycle(2);

    pulse(1'b1, 1'b1);
    chk("idle_both_state", state, 0);

`ifdef COUNTER_CTRL_AUTORELOAD_EN
    dir_sel = 1'b1;
    target  = 4'd2;
    pulse(1'b1, 1'b0);
    step_after("ar_s1", 3);
    chk("ar_q1", count_q, 1);
    step_after("ar_s2", 4);
    chk("ar_q2", count_q, 2);
    cycle(1);
    chk("ar_done_early", done, 0);
    cycle(1);
    chk("ar_done_pulse", done, 1);
    chk("ar_clr_pulse", cnt_resetn, 0);
    chk("ar_q0", count_q, 0);
    chk("ar_state", state, 1);
    cycle(1);
    chk("ar_done_drop", done, 0);
    chk("ar_clr_drop", cnt_resetn, 1);
    // Prescaler keeps running: next step lands one cycle later, 4 after step 2.
    step_after("ar_s3", 1);
    chk("ar_q3", count_q, 1);
    step_after("ar_s4", 4);
    chk("ar_q4", count_q, 2);
    cycle(2);
    chk("ar_done2", done, 1);
    chk("ar_q5", count_q, 0);
    chk("ar_state2", state, 1);
    pulse(1'b0, 1'b1);
    pulse(1'b0, 1'b1);
    chk("ar_abort", state, 0);
`else
    // Up-count to 3; later dir/target changes must be ignored.
    dir_sel = 1'b1;
    target  = 4'd3;
    pulse(1'b1, 1'b0);
    chk("up_state", state, 1);
    chk("up_cnt_resetn", cnt_resetn, 1);
    dir_sel = 1'b0;
    target  = 4'd0;
    step_after("up_s1", 3);
    chk("up_q1", count_q, 1);
    step_after("up_s2", 4);
    chk("up_q2", count_q, 2);
    step_after("up_s3", 4);
    chk("up_q3", count_q, 3);
    cycle(1);
    chk("up_step_width", step, 0);
    chk("up_done_early", done, 0);
    cycle(1);
    chk("up_done", done, 1);
    chk("up_done_state", state, 3);
    chk("up_updown", updown, 1);
    cycle(8);
    chk("up_hold_q", count_q, 3);
    pulse(1'b0, 1'b1);
    chk("up_abort_state", state, 0);
    chk("up_abort_clr", cnt_resetn, 0);
    chk("up_abort_q", count_q, 0);
    chk("up_abort_done", done, 0);

    // Down-count from 0 wraps to 9 first.
    dir_sel = 1'b0;
    target  = 4'd7;
    pulse(1'b1, 1'b0);
    chk("dn_updown", updown, 0);
    step_after("dn_s1", 3);
    chk("dn_q1", count_q, 9);
    chk("dn_no_done", state, 1);
    step_after("dn_s2", 4);
    chk("dn_q2", count_q, 8);
    step_after("dn_s3", 4);
    chk("dn_q3", count_q, 7);
    cycle(2);
    chk("dn_done", done, 1);
    pulse(1'b1, 1'b0);
    chk("dn_start_idle", state, 0);

    // Pause one cycle after step 2: one counting edge used, three remain.
    dir_sel = 1'b1;
    target  = 4'd5;
    pulse(1'b1, 1'b0);
    step_after("ps_s1", 3);
    step_after("ps_s2", 4);
    cycle(1);
    pulse(1'b0, 1'b1);
    chk("ps_state", state, 2);
    quiet = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1);
      if (step) quiet++;
    end
    chk("ps_no_steps", quiet, 0);
    chk("ps_hold_q", count_q, 2);
    pulse(1'b1, 1'b0);
    chk("ps_resume_state", state, 1);
    step_after("ps_s3", 3);
    chk("ps_q3", count_q, 3);
    step_after("ps_s4", 4);
    step_after("ps_s5", 4);
    chk("ps_q5", count_q, 5);
    cycle(2);
    chk("ps_done", state, 3);
    pulse(1'b0, 1'b1);

    // Simultaneous start+stop in PAUSE aborts to IDLE.
    dir_sel = 1'b1;
    target  = 4'd8;
    pulse(1'b1, 1'b0);
    step_after("ab_s1", 3);
    step_after("ab_s2", 4);
    pulse(1'b0, 1'b1);
    chk("ab_pause", state, 2);
    pulse(1'b1, 1'b1);
    chk("ab_state", state, 0);
    chk("ab_clr", cnt_resetn, 0);
    chk("ab_q", count_q, 0);

    // Unreachable target 12, counting down: free-runs until reset.
    dir_sel = 1'b0;
    target  = 4'd12;
    pulse(1'b1, 1'b0);
    for (int i = 1; i <= 12; i++) begin
      step_after("fr_step", (i == 1) ? 3 : 4);
      if (i == 10) chk("fr_q10", count_q, 0);
    end
    chk("fr_q12", count_q, 8);
    chk("fr_done", done, 0);
    chk("fr_state", state, 1);
    chk("fr_step_hi", step, 1);
    sResetn = 1'b0;
    #2;
    chk("ar_step", step, 0);
    chk("ar_clr", cnt_resetn, 0);
    chk("ar_updown", updown, 1);
    chk("ar_state", state, 0);
    chk("ar_q", count_q, 0);
    #2;
    sResetn = 1'b1;
    cycle(2);

    // Target 0 counting up needs a full lap of ten steps.
    dir_sel = 1'b1;
    target  = 4'd0;
    pulse(1'b1, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      step_after("t0_step", (i == 1) ? 3 : 4);
      if (i == 9) chk("t0_q9", count_q, 9);
    end
    chk("t0_q10", count_q, 0);
    cycle(1);
    chk("t0_not_yet", state, 1);
    cycle(1);
    chk("t0_done", done, 1);
    chk("t0_state", state, 3);
    pulse(1'b0, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
